// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and sizing helper for the UART TX arbiter.
package uart_pkg;

    typedef enum logic {IDLE, XFER} uart_arb_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotating priority encoder; one-hot of the first request at or above i_ptr, wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ_ = 4,
    parameter int IDX_W  = idx_width(N_REQ_)
) (
    input  logic [N_REQ_-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [N_REQ_-1:0] o_pick,
    output logic              o_found
);

    always_comb begin
        o_pick  = '0;
        o_found = 1'b0;
        for (int k = 0; k < N_REQ_; k++) begin
            if (!o_found && i_req[(int'(i_ptr) + k) % N_REQ_]) begin
                o_pick[(int'(i_ptr) + k) % N_REQ_] = 1'b1;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of the UART TX write port.
// Define UART_TX_ARB_TIMEOUT_EN to revoke a grant whose owner idles for TIMEOUT_ cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ_   = 4,
    parameter int DATA_    = 8,
    parameter int TIMEOUT_ = 1024
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic [N_REQ_-1:0]       req_valid,
    input  logic [N_REQ_-1:0]       req_last,
    input  logic [N_REQ_*DATA_-1:0] req_data,
    output logic [N_REQ_-1:0]       req_ready,
    input  logic                    uart_full,
    output logic                    uart_we,
    output logic [DATA_-1:0]        uart_wdata,
    output logic [N_REQ_-1:0]       grant,
    output logic                    busy
);

    localparam int IDX_W = idx_width(N_REQ_);

    uart_arb_state_t   r_state, w_state_nx;
    logic [N_REQ_-1:0] r_grant, w_grant_nx, w_pick;
    logic [IDX_W-1:0]  r_owner, w_owner_nx, r_ptr, w_ptr_nx, w_pick_idx, w_owner_inc;
    logic              w_found, w_xfer, w_owner_valid, w_accept, w_timeout, w_release;

    uart_rr_pick #(.N_REQ_(N_REQ_), .IDX_W(IDX_W)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < N_REQ_; k++)
            if (w_pick[k]) w_pick_idx = IDX_W'(k);
    end

    assign w_xfer        = (r_state == XFER);
    assign w_owner_valid = req_valid[r_owner];
    assign w_accept      = w_xfer & w_owner_valid & ~uart_full;
    assign w_owner_inc   = (r_owner == IDX_W'(N_REQ_ - 1)) ? '0 : r_owner + 1'b1;
    assign w_release     = (w_accept & req_last[r_owner]) | w_timeout;

    // r_grant is zero outside XFER, so ready needs no state qualification.
    assign grant      = r_grant;
    assign busy       = w_xfer;
    assign req_ready  = uart_full ? '0 : r_grant;
    assign uart_we    = w_accept;
    assign uart_wdata = req_data[r_owner*DATA_ +: DATA_];

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_owner_nx = r_owner;
        w_ptr_nx   = r_ptr;
        if (!w_xfer && w_found) begin
            w_state_nx = XFER;
            w_grant_nx = w_pick;
            w_owner_nx = w_pick_idx;
        end else if (w_release) begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
            w_ptr_nx   = w_owner_inc;
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_owner <= w_owner_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_ + 1);

    logic [CNT_W-1:0] r_idle_cnt;

    // Only owner-idle cycles count; backpressured cycles leave the count alone.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_)
            r_idle_cnt <= '0;
        else if (!w_xfer || w_accept || w_timeout)
            r_idle_cnt <= '0;
        else if (!w_owner_valid)
            r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    assign w_timeout = w_xfer & (r_idle_cnt == CNT_W'(TIMEOUT_));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_ != 0);
    assign w_timeout        = 1'b0;
`endif

endmodule
